// File: rtl/shot_sprite_gen.sv
// ---------------------------------------------------------------------------
// shot_sprite_gen
// Procedural, animated shot sprite. It replaces the stored 16x16 bitmap with a
// disc that has a core, a rim and an upper-left highlight. The disc radius
// pulses between RADIUS_MIN and RADIUS_MAX and steps once every
// FRAMES_PER_STEP frames. Pixels go through a registered 2-clock pipeline.
//
// Ports:
//   clk             pixel clock
//   reset           synchronous, active-high reset
//   startOfFrame    one-cycle pulse per video frame
//   enable          shot alive (level)
//   InsideRectangle current pixel lies inside the shot square
//   offsetX/Y       pixel column/row within the square (SIZE_BITS)
//   drawingRequest  pixel is opaque (registered, 2 clocks after inputs)
//   RGBout          pixel colour (registered, 2 clocks after inputs)
//   radius          current disc radius, for collision logic
//   expired         (SHOT_LIFETIME_EN only) one-clock pulse at end of life
//
// Optional feature macro: SHOT_LIFETIME_EN. It adds parameter LIFETIME_FRAMES,
// output expired and FSM state DONE.
// ---------------------------------------------------------------------------
module shot_sprite_gen #(
  parameter int unsigned SIZE_BITS       = 4,
  parameter int unsigned RADIUS_MIN      = 4,
  parameter int unsigned RADIUS_MAX      = 7,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter logic [7:0]  CORE_COLOR      = 8'hE9,
  parameter logic [7:0]  RIM_COLOR       = 8'hF0,
  parameter logic [7:0]  HILITE_COLOR    = 8'hFB,
  parameter logic [7:0]  TRANSPARENT     = 8'hFF
`ifdef SHOT_LIFETIME_EN
  ,
  parameter int unsigned LIFETIME_FRAMES = 120
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic                 InsideRectangle,
  input  logic [SIZE_BITS-1:0] offsetX,
  input  logic [SIZE_BITS-1:0] offsetY,
  output logic                 drawingRequest,
  output logic [7:0]           RGBout,
  output logic [SIZE_BITS-1:0] radius
`ifdef SHOT_LIFETIME_EN
  ,
  output logic                 expired
`endif
);

  localparam int unsigned DW    = SIZE_BITS + 2;
  localparam int unsigned D2W   = 2 * DW;
  localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DW-1:0] CENTER = DW'(1) << SIZE_BITS;
  localparam logic [SIZE_BITS-1:0] R_MIN = SIZE_BITS'(RADIUS_MIN);
  localparam logic [SIZE_BITS-1:0] R_MAX = SIZE_BITS'(RADIUS_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
`ifdef SHOT_LIFETIME_EN
  localparam int unsigned LW = $clog2(LIFETIME_FRAMES + 1);
  localparam logic [LW-1:0] LIFE_LAST = LW'(LIFETIME_FRAMES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GROW   = 2'd1,
    S_SHRINK = 2'd2
`ifdef SHOT_LIFETIME_EN
    ,
    S_DONE   = 2'd3
`endif
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [SIZE_BITS-1:0]  r_radius;
`ifdef SHOT_LIFETIME_EN
  logic [LW-1:0]         r_life;
  logic                  r_expired;
`endif

  // Stage-1 pipeline registers
  logic signed [DW-1:0]  r_dx1;
  logic signed [DW-1:0]  r_dy1;
  logic                  r_inside1;
  logic                  r_act1;
  logic [SIZE_BITS-1:0]  r_rad1;

  // Doubled, centred coordinates: 2*offset+1-2^SIZE_BITS
  logic signed [DW-1:0]  w_dx;
  logic signed [DW-1:0]  w_dy;
  logic                  w_active;

  assign w_dx     = {1'b0, offsetX, 1'b1} - CENTER;
  assign w_dy     = {1'b0, offsetY, 1'b1} - CENTER;
  assign w_active = (r_state == S_GROW) || (r_state == S_SHRINK);

  // Animation FSM: radius steps only on startOfFrame, so the disc never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_radius <= R_MIN;
`ifdef SHOT_LIFETIME_EN
      r_life    <= '0;
      r_expired <= 1'b0;
`endif
    end else begin
`ifdef SHOT_LIFETIME_EN
      r_expired <= 1'b0;
`endif
      if (!enable) begin
        // Dropping enable wins over a coincident frame pulse
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_radius <= R_MIN;
`ifdef SHOT_LIFETIME_EN
        r_life   <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_GROW;
          S_GROW, S_SHRINK: begin
            if (startOfFrame) begin
`ifdef SHOT_LIFETIME_EN
              if (r_life == LIFE_LAST) begin
                r_state   <= S_DONE;
                r_expired <= 1'b1;
              end else begin
                r_life <= r_life + LW'(1);
`endif
                if (r_cnt == CNT_LAST) begin
                  r_cnt <= '0;
                  if (r_state == S_GROW) begin
                    r_radius <= r_radius + SIZE_BITS'(1);
                    if (r_radius + SIZE_BITS'(1) == R_MAX) r_state <= S_SHRINK;
                  end else begin
                    r_radius <= r_radius - SIZE_BITS'(1);
                    if (r_radius - SIZE_BITS'(1) == R_MIN) r_state <= S_GROW;
                  end
                end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end
`ifdef SHOT_LIFETIME_EN
              end
`endif
            end
          end
`ifdef SHOT_LIFETIME_EN
          S_DONE: r_state <= S_DONE;
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage-2 geometry on stage-1 registers; squares kept at full width
  logic signed [D2W-1:0] w_dx_s;
  logic signed [D2W-1:0] w_dy_s;
  logic signed [D2W-1:0] w_dx2;
  logic signed [D2W-1:0] w_dy2;
  logic [D2W-1:0]        w_d2;
  logic [D2W-1:0]        w_r;
  logic [D2W-1:0]        w_rm1;
  logic [D2W-1:0]        w_rm2;
  logic [D2W-1:0]        w_th_rim;
  logic [D2W-1:0]        w_th_core;
  logic [D2W-1:0]        w_th_hl;
  logic                  w_core;
  logic                  w_rim;
  logic                  w_hl;

  assign w_dx_s    = D2W'(r_dx1);
  assign w_dy_s    = D2W'(r_dy1);
  assign w_dx2     = w_dx_s * w_dx_s;
  assign w_dy2     = w_dy_s * w_dy_s;
  assign w_d2      = $unsigned(w_dx2) + $unsigned(w_dy2);
  assign w_r       = D2W'(r_rad1);
  assign w_rm1     = w_r - D2W'(1);
  assign w_rm2     = w_r - D2W'(2);
  assign w_th_rim  = (w_r * w_r) << 2;
  assign w_th_core = (w_rm1 * w_rm1) << 2;
  assign w_th_hl   = (w_rm2 * w_rm2) << 2;
  assign w_core    = (w_d2 < w_th_core);
  assign w_rim     = !w_core && (w_d2 < w_th_rim);
  // Highlight: outer band of the core in the upper-left quadrant
  assign w_hl      = w_core && r_dx1[DW-1] && r_dy1[DW-1] && (w_d2 >= w_th_hl);

  // Pixel pipeline: stage 1 captures coordinates, stage 2 the colour
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dx1          <= '0;
      r_dy1          <= '0;
      r_inside1      <= 1'b0;
      r_act1         <= 1'b0;
      r_rad1         <= R_MIN;
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT;
    end else begin
      r_dx1     <= w_dx;
      r_dy1     <= w_dy;
      r_inside1 <= InsideRectangle;
      r_act1    <= w_active;
      r_rad1    <= r_radius;
      if (r_inside1 && r_act1 && (w_core || w_rim)) begin
        drawingRequest <= 1'b1;
        if (w_hl)        RGBout <= HILITE_COLOR;
        else if (w_core) RGBout <= CORE_COLOR;
        else             RGBout <= RIM_COLOR;
      end else begin
        drawingRequest <= 1'b0;
        RGBout         <= TRANSPARENT;
      end
    end
  end

  assign radius = r_radius;
`ifdef SHOT_LIFETIME_EN
  assign expired = r_expired;
`endif

endmodule

// File: tb/tb_shot_sprite_gen.sv
// ---------------------------------------------------------------------------
// tb_shot_sprite_gen
// Directed bench for shot_sprite_gen with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_shot_sprite_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       enable;
  logic       InsideRectangle;
  logic [3:0] offsetX;
  logic [3:0] offsetY;
  logic       drawingRequest;
  logic [7:0] RGBout;
  logic [3:0] radius;

  int vectors     = 0;
  int miscompares = 0;

  shot_sprite_gen dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .InsideRectangle(InsideRectangle),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout),
    .radius         (radius)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic dr, input logic [7:0] rgb);
    chk({tag, ".dr"}, 32'(drawingRequest), 32'(dr));
    chk({tag, ".rgb"}, 32'(RGBout), 32'(rgb));
  endtask

  // Apply a pixel and wait out the 2-clock pipeline
  task automatic pixel(input logic [3:0] x, input logic [3:0] y, input logic ins);
    offsetX = x;
    offsetY = y;
    InsideRectangle = ins;
    step(2);
  endtask

  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step(1);
      startOfFrame = 1'b0;
      step(1);
    end
  endtask

  logic [7:0] tog;

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b0;
    InsideRectangle = 1'b0; offsetX = 4'd0; offsetY = 4'd0;
    step(2);
    chk_px("reset", 1'b0, 8'hFF);
    chk("reset.radius", 32'(radius), 32'd4);

    // Basic disc at radius 4
    reset = 1'b0; enable = 1'b1;
    InsideRectangle = 1'b1; offsetX = 4'd8; offsetY = 4'd8;
    step(4);
    chk_px("r4.center", 1'b1, 8'hE9);
    pixel(4'd4, 4'd8, 1'b1);
    chk_px("r4.rim", 1'b1, 8'hF0);
    pixel(4'd6, 4'd6, 1'b1);
    chk_px("r4.hilite", 1'b1, 8'hFB);
    pixel(4'd0, 4'd0, 1'b1);
    chk_px("r4.corner", 1'b0, 8'hFF);
    pixel(4'd8, 4'd8, 1'b0);
    chk_px("outside_rect", 1'b0, 8'hFF);

    // InsideRectangle toggling shows up exactly 2 clocks later
    tog = 8'b1010_0101;
    offsetX = 4'd8; offsetY = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) chk("toggle.dr", 32'(drawingRequest), 32'(tog[i-2]));
      InsideRectangle = tog[i];
      step(1);
    end
    InsideRectangle = 1'b1;

    // Radius animation
    sof(3);
    chk("radius.3sof", 32'(radius), 32'd4);
    sof(1);
    chk("radius.4sof", 32'(radius), 32'd5);
    pixel(4'd4, 4'd8, 1'b1);
    chk_px("r5.core", 1'b1, 8'hE9);
    sof(8);
    chk("radius.12sof", 32'(radius), 32'd7);
    pixel(4'd1, 4'd8, 1'b1);
    chk_px("r7.rim", 1'b1, 8'hF0);
    pixel(4'd0, 4'd8, 1'b1);
    chk_px("r7.edge", 1'b0, 8'hFF);
    sof(4);
    chk("radius.16sof", 32'(radius), 32'd6);
    sof(8);
    chk("radius.24sof", 32'(radius), 32'd4);
    sof(4);
    chk("radius.28sof", 32'(radius), 32'd5);

    // Drop enable together with the step-completing frame pulse at radius 7
    sof(8);
    chk("radius.36sof", 32'(radius), 32'd7);
    sof(3);
    chk("radius.39sof", 32'(radius), 32'd7);
    startOfFrame = 1'b1; enable = 1'b0;
    step(1);
    startOfFrame = 1'b0;
    chk("disable.radius", 32'(radius), 32'd4);
    pixel(4'd8, 4'd8, 1'b1);
    chk_px("disable.px", 1'b0, 8'hFF);
    sof(4);
    chk("idle.no_count", 32'(radius), 32'd4);

    // Reset mid-SHRINK at radius 6
    enable = 1'b1;
    step(1);
    sof(16);
    chk("pre_reset.radius", 32'(radius), 32'd6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("post_reset.radius", 32'(radius), 32'd4);
    chk_px("post_reset.px", 1'b0, 8'hFF);
    step(1);
    sof(4);
    chk("resume.radius", 32'(radius), 32'd5);
    pixel(4'd8, 4'd8, 1'b1);
    chk_px("resume.px", 1'b1, 8'hE9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shot_sprite_gen.md
Name: shot_sprite_gen

Overview:
- Procedural, animated successor to the fixed 16x16 shot bitmap.
- Computes each shot pixel from a parametrised disc (core, rim and highlight) instead of a stored ROM.
- Pulses the disc radius between a minimum and a maximum, stepping once per N video frames.
- Sits between the shot's square-object locator (offsets plus inside flag) and the video mux, with a registered 2-cycle pixel pipeline.

Parameters:
- SIZE_BITS, 4, sprite edge = 2^SIZE_BITS pixels (default 16).
- RADIUS_MIN, 4, smallest disc radius in pixels (>=2).
- RADIUS_MAX, 7, largest disc radius in pixels (<= 2^(SIZE_BITS-1)-1, > RADIUS_MIN).
- FRAMES_PER_STEP, 4, startOfFrame pulses per radius step (>=1).
- CORE_COLOR, 8'hE9, disc interior colour.
- RIM_COLOR, 8'hF0, outer ring colour.
- HILITE_COLOR, 8'hFB, upper-left highlight colour.
- TRANSPARENT, 8'hFF, colour driven when not drawing.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- enable  in  1  shot is alive; level signal.
- InsideRectangle  in  1  current pixel lies inside the shot's square.
- offsetX  in  SIZE_BITS  pixel column within the square.
- offsetY  in  SIZE_BITS  pixel row within the square.
- drawingRequest  out  1  pixel is opaque.
- RGBout  out  8  pixel colour.
- radius  out  SIZE_BITS  current disc radius, for the collision logic.

Behaviour:
- Reset (synchronous, active-high): drawingRequest=0, RGBout=TRANSPARENT, radius=RADIUS_MIN, FSM=IDLE, frame counter=0, pipeline valid bits cleared. Reset asserted mid-animation takes effect on the next edge and has priority over every other input.
- FSM states: IDLE, GROW, SHRINK.
  - IDLE -> GROW when enable=1. Radius is RADIUS_MIN and the counter is 0 on entry.
  - Any state -> IDLE when enable=0. Radius returns to RADIUS_MIN and the counter clears.
  - If enable falls on the same cycle as startOfFrame, the IDLE transition wins and no step occurs.
- Frame counter: counts startOfFrame only in GROW/SHRINK. Range 0..FRAMES_PER_STEP-1. On a startOfFrame with the counter at FRAMES_PER_STEP-1 the counter wraps to 0 and the radius steps.
  - GROW: radius+1. When the new radius equals RADIUS_MAX, the state goes to SHRINK.
  - SHRINK: radius-1. When the new radius equals RADIUS_MIN, the state goes to GROW.
- Radius changes only on startOfFrame, so the disc never tears mid-frame.
- Geometry uses doubled, centred coordinates:
  - dx = 2*offsetX+1-2^SIZE_BITS and dy likewise, both signed SIZE_BITS+2 bits.
  - d2 = dx*dx+dy*dy, unsigned 2*(SIZE_BITS+2) bits with no truncation.
  - Core: d2 < 4*(r-1)^2.
  - Rim: 4*(r-1)^2 <= d2 < 4*r^2.
  - Outside: everything else.
  - Highlight: a core pixel with dx<0, dy<0 and d2 >= 4*(r-2)^2.
  - Colour priority: highlight > core > rim.
- Pipeline:
  - Stage 1 registers dx, dy, InsideRectangle and enable-active.
  - Stage 2 registers drawingRequest and RGBout.
  - Latency from offset/InsideRectangle input to output is exactly 2 clocks.
- drawingRequest=1 only when the stage-1 inside flag is set, the FSM was non-IDLE and the pixel is core or rim. Otherwise drawingRequest=0 and RGBout=TRANSPARENT.
- The radius used in stage 2 is the value registered at stage-1 capture.

Optional Feature:
- Macro: SHOT_LIFETIME_EN.
- Defined:
  - Adds parameter LIFETIME_FRAMES (default 120) and output port expired (1 bit).
  - Adds FSM state DONE and a lifetime counter that counts startOfFrame while in GROW/SHRINK.
  - At the LIFETIME_FRAMES-th pulse the FSM enters DONE and expired pulses high for exactly one clock.
  - In DONE, drawingRequest=0 and RGBout=TRANSPARENT; the FSM stays there until enable=0, then returns to IDLE.
  - expired resets to 0.
- Undefined: no port, no counter and no DONE state; the shot animates indefinitely while enabled.

Test Plan:
- Defaults, after reset, enable=1, InsideRectangle=1, radius 4:
  - offset (8,8) -> 2 clocks later drawingRequest=1, RGBout=E9.
  - offset (4,8) -> F0.
  - offset (6,6) -> FB.
  - offset (0,0) -> drawingRequest=0, RGBout=FF.
- enable=1, 4 startOfFrame pulses -> radius=5. After 12 pulses -> radius=7 and state SHRINK. After 16 pulses -> radius=6. After 24 pulses -> radius=4 and state GROW.
- Radius 7, enable dropped on the same cycle as startOfFrame -> next cycle FSM=IDLE, radius=4, and offset (8,8) yields drawingRequest=0.
- InsideRectangle=0 with offset (8,8) and enable=1 -> drawingRequest=0, RGBout=FF. Toggling InsideRectangle each clock -> output toggles exactly 2 clocks delayed.
- reset pulsed for one clock at radius 6 mid-SHRINK -> next cycle radius=4, FSM=IDLE, drawingRequest=0; the disc resumes growing from 4 with enable held.
- SHOT_LIFETIME_EN, LIFETIME_FRAMES=10 -> expired high for one clock after the 10th startOfFrame, no drawing afterwards; enable 0 then 1 -> animation restarts at radius 4.
